// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed active-low 7-segment bus and publishes stable BCD digits.
// Define SEG7_READER_SYNC_EN to put a 2-flop synchronizer on seg/an (bus from another clock domain or a pin).
module seg7_scan_reader #(
   parameter int DIGITS        = 4,
   parameter int STABLE_FRAMES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  valid,
   output logic                  err
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

   logic [6:0]          seg_q;
   logic [DIGITS-1:0]   an_q;

`ifdef SEG7_READER_SYNC_EN
   logic [6:0]          seg_m;
   logic [DIGITS-1:0]   an_m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_m <= '1;
         seg_q <= '1;
         an_m  <= '1;
         an_q  <= '1;
      end else begin
         seg_m <= seg;
         seg_q <= seg_m;
         an_m  <= an;
         an_q  <= an_m;
      end
   end
`else
   assign seg_q = seg;
   assign an_q  = an;
`endif

   logic [6:0]          pat;
   logic [DIGITS-1:0]   act;
   logic                onehot;

   assign pat    = ~seg_q;
   assign act    = ~an_q;
   assign onehot = (act != '0) && ((act & (act - DIGITS'(1))) == '0);

   // {bad, blank, value}; blank and invalid both carry a 4'hF value field
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'h3F:         r = {2'b00, 4'd0};
         7'h06:         r = {2'b00, 4'd1};
         7'h5B:         r = {2'b00, 4'd2};
         7'h4F:         r = {2'b00, 4'd3};
         7'h66:         r = {2'b00, 4'd4};
         7'h6D:         r = {2'b00, 4'd5};
         7'h7D, 7'h7C:  r = {2'b00, 4'd6};
         7'h07, 7'h27:  r = {2'b00, 4'd7};
         7'h7F:         r = {2'b00, 4'd8};
         7'h6F, 7'h67:  r = {2'b00, 4'd9};
         7'h00:         r = {2'b01, 4'hF};
         default:       r = {2'b10, 4'hF};
      endcase
      return r;
   endfunction

   logic [DIGITS-1:0]   act_prev;
   logic                cap_done;
   logic                capture;
   logic [5:0]          dec;

   // capture once, on the second cycle of a steady one-hot enable
   assign capture = onehot && (act == act_prev) && !cap_done;
   assign dec     = decode(pat);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_prev <= '0;
         cap_done <= 1'b0;
      end else begin
         act_prev <= onehot ? act : '0;
         cap_done <= onehot && (act == act_prev);
      end
   end

   logic [4*DIGITS-1:0] frm_bcd;
   logic [DIGITS-1:0]   frm_blank;
   logic [DIGITS-1:0]   frm_bad;
   logic [DIGITS-1:0]   seen;
   logic                frame_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_bcd   <= '1;
         frm_blank <= '1;
         frm_bad   <= '0;
         seen      <= '0;
         frame_end <= 1'b0;
      end else begin
         frame_end <= 1'b0;
         if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (act[i]) begin
                  frm_bcd[4*i +: 4] <= dec[3:0];
                  frm_blank[i]      <= dec[4];
                  frm_bad[i]        <= dec[5];
               end
            end
            if ((seen | act) == '1) begin
               seen      <= '0;
               frame_end <= 1'b1;
            end else begin
               seen <= seen | act;
            end
         end
      end
   end

   logic [4*DIGITS-1:0] cand_bcd,   cand_bcd_nxt;
   logic [DIGITS-1:0]   cand_blank, cand_blank_nxt;
   logic [3:0]          cnt,        cnt_nxt;
   logic                any_bad;
   logic                frm_match;
   logic                publish;
   logic                err_nxt;

   assign any_bad   = |frm_bad;
   assign frm_match = (frm_bcd == cand_bcd) && (frm_blank == cand_blank);

   always_comb begin
      cand_bcd_nxt   = cand_bcd;
      cand_blank_nxt = cand_blank;
      cnt_nxt        = cnt;
      err_nxt        = 1'b0;
      publish        = 1'b0;
      if (frame_end) begin
         if (any_bad) begin
            err_nxt        = 1'b1;
            cnt_nxt        = '0;
            cand_bcd_nxt   = '1;
            cand_blank_nxt = '1;
         end else begin
            if (frm_match) begin
               cnt_nxt = (cnt >= STABLE_CNT) ? STABLE_CNT : cnt + 4'd1;
            end else begin
               cand_bcd_nxt   = frm_bcd;
               cand_blank_nxt = frm_blank;
               cnt_nxt        = 4'd1;
            end
            // candidate now equals the frame, so compare the frame to what is published
            publish = (cnt_nxt == STABLE_CNT) &&
                      ((frm_bcd != bcd) || (frm_blank != blank));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_bcd   <= '1;
         cand_blank <= '1;
         cnt        <= '0;
         bcd        <= '1;
         blank      <= '1;
         valid      <= 1'b0;
         err        <= 1'b0;
      end else begin
         cand_bcd   <= cand_bcd_nxt;
         cand_blank <= cand_blank_nxt;
         cnt        <= cnt_nxt;
         valid      <= publish;
         err        <= err_nxt;
         if (publish) begin
            bcd   <= frm_bcd;
            blank <= frm_blank;
         end
      end
   end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the team's BCD-to-7-segment decoder: watches a multiplexed, active-low 7-segment display bus (segment lines plus digit enables) and recovers the BCD digit values being shown. Each scanned digit is captured, decoded back to BCD, assembled into a frame, and filtered for stability over consecutive frames before it is published. The block is used in benches and on-board self-checks to read back what a display driver is actually emitting.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits (1–8)
- STABLE_FRAMES, 2, consecutive identical error-free frames required before outputs update (1–15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- seg  in  7  segment lines, active-low; seg[0]=a … seg[6]=g
- an  in  DIGITS  digit enables, active-low; an[i] low selects digit i
- bcd  out  4*DIGITS  published BCD; digit i at bcd[4*i+3:4*i]
- blank  out  DIGITS  published blank flags; 1 = digit shown with all segments off
- valid  out  1  one-cycle pulse when bcd/blank are loaded with a new value
- err  out  1  one-cycle pulse when a frame contains an undecodable pattern

## Operation
- Inputs are inverted internally to active-high: P = ~seg (gfedcba), A = ~an.
- Digit capture: A must be one-hot. A digit i is captured on the 2nd consecutive cycle with the same one-hot A (1-cycle settle); one capture per activation. A zero or multi-hot A resets settle tracking and captures nothing.
- Decode of P (hex, gfedcba): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D or 7C→6, 07 or 27→7, 7F→8, 6F or 67→9, 00→blank (BCD field 4'hF, blank bit 1). Any other pattern is invalid.
- Frame: a DIGITS-bit "seen" mask is set on each capture; re-capturing an already-seen digit overwrites it. The frame ends on the capture that makes the mask all ones; the mask then clears.
- Frame end, invalid digit present: err pulses, stability count clears to 0, candidate discarded, outputs unchanged.
- Frame end, all valid: if the frame equals the candidate, the count increments (saturating at STABLE_FRAMES); otherwise the candidate is replaced and the count is set to 1.
- When count == STABLE_FRAMES and the candidate differs from the published bcd/blank: load outputs and pulse valid. An unchanged stable frame produces no pulse.
- Reset (any time, including mid-frame): seen mask, candidate, count and settle tracking clear; partial frame discarded.

## Timing
- Reset values: bcd = all 4'hF, blank = all ones, valid = 0, err = 0; count = 0.
- Capture → decoded field registered in the same edge; frame-end decision registered one cycle later: valid/err asserted the cycle after the completing capture, for exactly one cycle.
- valid and err are never asserted in the same cycle.
- Minimum digit dwell: 2 cycles (plus synchronizer depth if enabled); shorter activations are ignored.
- Throughput: one frame decision per full scan; STABLE_FRAMES=1 publishes on the first valid frame.

## Configuration
- SEG7_READER_SYNC_EN defined: seg and an pass through a 2-flop synchronizer (reset to all ones, i.e. inactive) before capture logic; all latencies grow by 2 cycles. Required when the bus comes from another clock domain or a pin.
- Undefined: seg and an are sampled directly; bus must be synchronous to clk.

## Test plan
- Reset: assert rst_n=0 mid-scan -> bcd=16'hFFFF, blank=4'hF, valid=0, err=0 immediately; after release, a partial frame never produces valid.
- Stable scan, DIGITS=4, STABLE_FRAMES=2: digits 1,2,3,4 (seg=~06,~5B,~4F,~66), each dwelling 4 cycles, repeated -> valid once after the 2nd frame, bcd=16'h4321, blank=0; no further valid on later identical frames.
- Tail variants: digit shows 7C then 7D in alternating frames -> both decode to 6, count keeps advancing, single valid with field=6.
- Invalid pattern: one digit shows 0x49 -> err pulse at that frame end, outputs hold previous value, next two clean frames required before valid.
- Blank + glitch: digit 3 shows 00, an briefly 4'b0000 and 4'b1100 between digits -> blank[3]=1, bcd[15:12]=F, glitch cycles produce no capture.
- Compile with SEG7_READER_SYNC_EN: repeat stable-scan case -> same bcd, valid delayed exactly 2 cycles versus unsynchronized build.
